// File: rtl/bsg_cgol_pkg.sv
// Shared types and sizing constants for the Game of Life controller and cell grid.
package bsg_cgol_pkg;

  localparam int board_width_gp = 8;
  localparam int max_frames_gp  = 255;

  typedef enum logic [1:0] {
    eIdle,
    eLoad,
    eRun,
    eDone
  } bsg_cgol_ctrl_state_e;

endpackage

// File: rtl/bsg_cgol_frame_counter.sv
// Loadable down-counter of remaining generations; holds at zero instead of wrapping.
module bsg_cgol_frame_counter #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] val_i,
  input  logic               dec_i,
  output logic               zero_o,
  output logic               one_o
);

  logic [width_p-1:0] count_r;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (load_i) begin
      count_r <= val_i;
    end else if (dec_i && (count_r != '0)) begin
      count_r <= count_r - width_p'(1);
    end
  end

  assign zero_o = (count_r == '0);
  assign one_o  = (count_r == width_p'(1));

endmodule

// File: rtl/bsg_cgol_ctrl.sv
// Job sequencer for the cell grid: load seed, pulse en_o once per generation, offer result.
module bsg_cgol_ctrl
  import bsg_cgol_pkg::*;
#(
  parameter  int board_width_p   = board_width_gp,
  parameter  int max_frames_p    = max_frames_gp,
  localparam int frames_width_lp = $clog2(max_frames_p + 1),
  localparam int cells_lp        = board_width_p * board_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [cells_lp-1:0]        data_i,
  input  logic [frames_width_lp-1:0] frames_i,
  output logic                       ready_o,
  output logic                       update_o,
  output logic [cells_lp-1:0]        update_val_o,
  output logic                       en_o,
  input  logic [cells_lp-1:0]        grid_data_i,
  output logic                       v_o,
  output logic [cells_lp-1:0]        data_o,
  input  logic                       yumi_i
);

  bsg_cgol_ctrl_state_e state_r;
  logic [cells_lp-1:0]  board_r;
  logic                 frames_zero;
  logic                 frames_one;
  logic                 accept;

  assign accept = (state_r == eIdle) && v_i;

  bsg_cgol_frame_counter #(
    .width_p(frames_width_lp)
  ) frame_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (accept),
    .val_i    (frames_i),
    .dec_i    (state_r == eRun),
    .zero_o   (frames_zero),
    .one_o    (frames_one)
  );

  // Strobes are registered alongside the state so each one is a clean flop output.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= eIdle;
      board_r  <= '0;
      ready_o  <= 1'b1;
      update_o <= 1'b0;
      en_o     <= 1'b0;
      v_o      <= 1'b0;
    end else begin
      unique case (state_r)
        eIdle: if (accept) begin
          board_r  <= data_i;
          state_r  <= eLoad;
          ready_o  <= 1'b0;
          update_o <= 1'b1;
        end
        eLoad: begin
          update_o <= 1'b0;
          if (!frames_zero) begin
            state_r <= eRun;
            en_o    <= 1'b1;
          end else begin
            state_r <= eDone;
            v_o     <= 1'b1;
          end
        end
        eRun: if (frames_one || frames_zero) begin
          state_r <= eDone;
          en_o    <= 1'b0;
          v_o     <= 1'b1;
        end
        eDone: if (yumi_i) begin
          state_r <= eIdle;
          v_o     <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  assign update_val_o = board_r;
  // The grid is frozen while v_o is high, so the result is the live cell state.
  assign data_o       = grid_data_i;

endmodule

// File: doc/bsg_cgol_ctrl.md
# bsg_cgol_ctrl

Sequencing controller for the Conway's Game of Life cell array. It accepts a seed board and a generation count over a ready/valid input. It loads the board into every cell through the per-cell update path, then asserts the compute enable for exactly the requested number of cycles. Finally it presents the resulting board on a valid/yumi output. It sits between the host-side FIFO and the `board_width_p` × `board_width_p` grid of `bsg_cgol_cell` instances.

## Interface
Parameters:
- `board_width_p`, default 8: board is `board_width_p`² cells. Cell (r,c) maps to bit `r*board_width_p+c`.
- `max_frames_p`, default 255: largest generation count accepted.
- `frames_width_lp` (local): `$clog2(max_frames_p+1)`.
- `cells_lp` (local): `board_width_p*board_width_p`.

Ports:
- `clk_i` in 1: the single clock; all state changes on its rising edge.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `v_i` in 1: seed board and frame count valid.
- `data_i` in `cells_lp`: seed board.
- `frames_i` in `frames_width_lp`: number of generations to simulate.
- `ready_o` out 1: controller can accept a job.
- `update_o` out 1: drives every cell's `update_i`.
- `update_val_o` out `cells_lp`: per-cell `update_val_i`.
- `en_o` out 1: drives every cell's `en_i`.
- `grid_data_i` in `cells_lp`: concatenated `data_o` of all cells.
- `v_o` out 1: result board valid.
- `data_o` out `cells_lp`: result board.
- `yumi_i` in 1: consumer takes the result. Legal only when `v_o`=1.

## Operation
The controller is a four-state FSM: `eIdle`, `eLoad`, `eRun`, `eDone`.

- **eIdle**
  - `ready_o`=1.
  - On `v_i & ready_o`: register `data_i` into `board_r` and `frames_i` into `frames_r`, then go to `eLoad`.
- **eLoad** (exactly 1 cycle)
  - `update_o`=1 and `update_val_o`=`board_r`. Cells take the board at this cycle's closing edge.
  - Next state is `eRun` if `frames_r`≠0, else `eDone`.
- **eRun**
  - `en_o`=1 every cycle; `frames_r` decrements each cycle.
  - When `frames_r`==1, go to `eDone`.
  - `frames_r` never wraps below 0.
- **eDone**
  - `v_o`=1 and `data_o`=`grid_data_i`. The grid is stable because `en_o`=0 and `update_o`=0.
  - On `yumi_i`, go to `eIdle`.

General rules:
- `update_o` and `en_o` are never both 1.
- Both are 0 in every state other than the one that drives them.
- `update_val_o` is `board_r` in all states, so it is a don't-care outside `eLoad`.
- `v_i` outside `eIdle` is ignored. The source must hold it until `ready_o`.
- `yumi_i` without `v_o` is a protocol error. Bench assertion only.

## Timing
- All outputs are driven from registered state.
- Reset values (asynchronous on `reset_n_i`=0):
  - state=`eIdle`, `ready_o`=1;
  - `update_o`=0, `en_o`=0, `v_o`=0;
  - `board_r`=0, `frames_r`=0.
- Reset mid-job: the job is abandoned immediately. Cells are not reset by this block and keep their last value.
- Latency for an accept at edge t with count F:
  - `eLoad` is the cycle after t;
  - `en_o` is high for cycles t+2 … t+1+F, giving exactly F pulses;
  - `v_o` rises at cycle t+2+F. For F=0, `v_o` rises at t+2.
- Result back-pressure: `v_o` and `data_o` hold indefinitely until `yumi_i`.
- After `yumi_i` at edge u, `ready_o`=1 in cycle u+1. There is no same-cycle turnaround.
- Throughput: one job per F+3 cycles minimum.

## Structure
- `bsg_cgol_pkg` holds:
  - the state typedef `bsg_cgol_ctrl_state_e` (`eIdle`, `eLoad`, `eRun`, `eDone`);
  - the default board width and maximum frame constants, shared with the cell-grid top.
- One sub-module, `bsg_cgol_frame_counter`, is natural:
  - a loadable down-counter with `zero_o` and `one_o` flags;
  - width `frames_width_lp`;
  - saturates at 0.
- The FSM and board register stay in `bsg_cgol_ctrl`.

## Test plan
The bench instantiates 8×8 `bsg_cgol_cell` grid plus controller.
- **Blinker, odd count:** seed bits {26,27,28}, F=3 → exactly 3 `en_o` pulses; `data_o`={19,27,35}; `v_o` at t+5.
- **Zero frames:** any seed, F=0 → zero `en_o` pulses; `v_o` at t+2; `data_o` equals the seed.
- **Back-pressure:** blinker with F=2, `yumi_i` held low for 10 cycles → `v_o` and `data_o`={26,27,28} stable throughout; `ready_o`=0 until the cycle after `yumi_i`.
- **Busy ignore:** `v_i` pulsed with a different board during `eRun` → ignored; original job's result is unchanged; second job accepted only after return to `eIdle`.
- **Mid-run reset:** blinker F=200, `reset_n_i` low at cycle 50 → `en_o` drops asynchronously; `ready_o`=1 after release; a new F=1 job completes correctly.
- **Back-to-back jobs:** glider, F=4, then F=max_frames_p → pulse counts match exactly; glider ends translated by (+1,+1) after 4 frames.
